// File: rtl/loop_addr_gen_2d.sv
// Two-level (outer row / inner word) read-address sequencer with a valid/ready output.
// Addresses are built incrementally from a running row base; no multiplier.
module loop_addr_gen_2d #(
    parameter int AW = 16,
    parameter int CW = 16
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          start,
    input  logic          abort,
    input  logic [CW-1:0] outer_end,
    input  logic [CW-1:0] inner_end,
    input  logic [AW-1:0] base_addr,
    input  logic [AW-1:0] stride,
    output logic          addr_valid,
    input  logic          addr_ready,
    output logic [AW-1:0] addr,
    output logic [CW-1:0] outer_idx,
    output logic [CW-1:0] inner_idx,
    output logic          last_inner,
    output logic          last,
    output logic          busy,
    output logic          done
);

    typedef enum logic [1:0] {S_IDLE, S_RUN, S_DONE} state_t;

    state_t        state_q, state_d;
    logic [AW-1:0] addr_q, addr_d;
    logic [AW-1:0] row_base_q, row_base_d;
    logic [CW-1:0] outer_q, outer_d;
    logic [CW-1:0] inner_q, inner_d;
    logic [CW-1:0] outer_end_q, outer_end_d;
    logic [CW-1:0] inner_end_q, inner_end_d;
    logic [AW-1:0] stride_q, stride_d;

    logic xfer;
    logic inner_at_end;
    logic outer_at_end;

    assign inner_at_end = (inner_q == inner_end_q);
    assign outer_at_end = (outer_q == outer_end_q);
    assign xfer         = (state_q == S_RUN) && addr_ready;

    assign addr_valid = (state_q == S_RUN);
    assign busy       = (state_q == S_RUN);
    assign done       = (state_q == S_DONE);
    assign addr       = addr_q;
    assign outer_idx  = outer_q;
    assign inner_idx  = inner_q;
    assign last_inner = addr_valid && inner_at_end;
    assign last       = addr_valid && inner_at_end && outer_at_end;

    always_comb begin
        state_d     = state_q;
        addr_d      = addr_q;
        row_base_d  = row_base_q;
        outer_d     = outer_q;
        inner_d     = inner_q;
        outer_end_d = outer_end_q;
        inner_end_d = inner_end_q;
        stride_d    = stride_q;

        case (state_q)
            S_IDLE: begin
                // start beats abort when both arrive in IDLE
                if (start) begin
                    outer_end_d = outer_end;
                    inner_end_d = inner_end;
                    stride_d    = stride;
                    row_base_d  = base_addr;
                    addr_d      = base_addr;
                    outer_d     = '0;
                    inner_d     = '0;
                    state_d     = S_RUN;
                end
            end
            S_RUN: begin
                if (abort) begin
                    state_d = S_IDLE;
                end else if (xfer) begin
                    if (!inner_at_end) begin
                        inner_d = inner_q + CW'(1);
                        addr_d  = addr_q + AW'(1);
                    end else if (!outer_at_end) begin
                        // next row: address restarts from the advanced row base
                        inner_d    = '0;
                        outer_d    = outer_q + CW'(1);
                        row_base_d = row_base_q + stride_q;
                        addr_d     = row_base_q + stride_q;
                    end else begin
                        state_d = S_DONE;
                    end
                end
            end
            S_DONE: begin
                state_d = S_IDLE;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q     <= S_IDLE;
            addr_q      <= '0;
            row_base_q  <= '0;
            outer_q     <= '0;
            inner_q     <= '0;
            outer_end_q <= '0;
            inner_end_q <= '0;
            stride_q    <= '0;
        end else begin
            state_q     <= state_d;
            addr_q      <= addr_d;
            row_base_q  <= row_base_d;
            outer_q     <= outer_d;
            inner_q     <= inner_d;
            outer_end_q <= outer_end_d;
            inner_end_q <= inner_end_d;
            stride_q    <= stride_d;
        end
    end

endmodule
